gb_capture_sched: RTL

- Capture-side controller for the Game Boy LCD to VGA scaler.
- Synchronises and glitch-filters the raw GB LCD bus (iclk, ihsync, ivsync, idata) into the VGA pixel clock domain.
- Sequences framebuffer writes as pixel address, data and write-strobe.
- Schedules a triple-buffered framebuffer, so the VGA scan-out always reads the latest complete frame with no tearing.

---
 rtl/gbvga_pkg.sv | 13 +
 rtl/gb_edge_sync.sv | 21 ++
 rtl/gb_capture_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/gbvga_pkg.sv
// Shared geometry, bank index type and capture FSM states for the GB LCD capture path.
package gbvga_pkg;
  localparam int H_PIX   = 160;
  localparam int V_LINES = 144;
  localparam int ADDR_W  = 15;

  typedef logic [1:0] bank_t;

  typedef enum logic {
    SEEK    = 1'b0,
    CAPTURE = 1'b1
  } cap_state_t;
endpackage

// File: rtl/gb_edge_sync.sv
// 4-flop synchroniser with a glitch-filtered rising-event detector.
// The event is asserted combinationally from the chain, three clk edges after the input rises.
module gb_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic [3:0] sync;  // sync[0] is s1, sync[3] is s4

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[2:0], din};
    end
  end

  // requiring both s2 and s3 high rejects single-cycle glitches
  assign rise = ~sync[3] & sync[2] & sync[1];
endmodule

// File: rtl/gb_capture_sched.sv
// GB LCD capture controller: synchronises the raw LCD bus, emits framebuffer writes and
// schedules a triple-buffered framebuffer; a pixel write appears one cycle after its event.
module gb_capture_sched #(
  parameter int H_PIX   = gbvga_pkg::H_PIX,
  parameter int V_LINES = gbvga_pkg::V_LINES,
  parameter int ADDR_W  = gbvga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iclk,
  input  logic              ihsync,
  input  logic              ivsync,
  input  logic [1:0]        idata,
  input  logic              swap_req,
  input  logic              status_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic [1:0]        wr_bank,
  output logic [1:0]        rd_bank,
  output logic              swap_ack,
  output logic              locked,
  output logic              err_overflow,
  output logic              err_short
);
  import gbvga_pkg::bank_t;
  import gbvga_pkg::cap_state_t;
  import gbvga_pkg::SEEK;
  import gbvga_pkg::CAPTURE;

  localparam logic [ADDR_W-1:0] HP = ADDR_W'(H_PIX);
  localparam logic [ADDR_W-1:0] VL = ADDR_W'(V_LINES);

  logic pix_rise, hs_rise, vs_rise;

  gb_edge_sync u_sync_pix (.clk(clk), .rst_n(rst_n), .din(iclk),   .rise(pix_rise));
  gb_edge_sync u_sync_hs  (.clk(clk), .rst_n(rst_n), .din(ihsync), .rise(hs_rise));
  gb_edge_sync u_sync_vs  (.clk(clk), .rst_n(rst_n), .din(ivsync), .rise(vs_rise));

  // data runs one flop shorter so d3 lines up with the pixel event
  logic [1:0] d1, d2, d3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else begin
      d1 <= idata;
      d2 <= d1;
      d3 <= d2;
    end
  end

  cap_state_t        state, state_n;
  logic [ADDR_W-1:0] x, x_n, y, y_n, line_base, base_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [1:0]        wr_data_n;
  logic              wr_en_n;
  logic              frame_done, set_ovf, set_short;

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    base_n     = line_base;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    frame_done = 1'b0;
    set_ovf    = 1'b0;
    set_short  = 1'b0;
    case (state)
      SEEK: begin
        if (vs_rise) begin
          state_n = CAPTURE;
          x_n     = '0;
          y_n     = '0;
          base_n  = '0;
        end
      end
      CAPTURE: begin
        // if/else order gives vsync > hsync > pixel; losers are dropped
        if (vs_rise) begin
          if (y == VL || (y == VL - 1'b1 && x == HP)) begin
            frame_done = 1'b1;
          end else if (y != '0 || x != '0) begin
            set_short = 1'b1;
          end
          x_n    = '0;
          y_n    = '0;
          base_n = '0;
        end else if (hs_rise) begin
          if (x != '0) begin
            y_n    = y + 1'b1;
            base_n = line_base + HP;
            x_n    = '0;
          end
        end else if (pix_rise) begin
          if (x < HP && y < VL) begin
            wr_en_n   = 1'b1;
            wr_addr_n = line_base + x;
            wr_data_n = d3;
            x_n       = x + 1'b1;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      default: state_n = SEEK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEEK;
      x         <= '0;
      y         <= '0;
      line_base <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      x         <= x_n;
      y         <= y_n;
      line_base <= base_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
    end
  end

  bank_t w_bank, l_bank, r_bank;
  logic  l_valid;

  // W, L and R only ever trade places, so they stay a permutation of {0,1,2}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_bank       <= 2'd0;
      l_bank       <= 2'd1;
      r_bank       <= 2'd2;
      l_valid      <= 1'b0;
      swap_ack     <= 1'b0;
      locked       <= 1'b0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      if (frame_done && swap_req) begin
        r_bank   <= w_bank;
        l_bank   <= r_bank;
        w_bank   <= l_bank;
        l_valid  <= 1'b0;
        swap_ack <= 1'b1;
      end else if (frame_done) begin
        w_bank  <= l_bank;
        l_bank  <= w_bank;
        l_valid <= 1'b1;
      end else if (swap_req && l_valid) begin
        r_bank   <= l_bank;
        l_bank   <= r_bank;
        l_valid  <= 1'b0;
        swap_ack <= 1'b1;
      end

      if (frame_done) begin
        locked <= 1'b1;
      end else if (set_short) begin
        locked <= 1'b0;
      end

      // a set in the same cycle as status_clr wins
      err_overflow <= set_ovf | (err_overflow & ~status_clr);
      err_short    <= set_short | (err_short & ~status_clr);
    end
  end

  assign wr_bank = w_bank;
  assign rd_bank = r_bank;
endmodule
